left_shift_pipe: RTL and testbench

- Pipelined logical left shifter for the ALU `sll` path. It is the left-direction counterpart of the combinational arithmetic right shifter.
- Splits the 5-layer log shifter into 5 registered stages, one shift layer per stage, to cut the critical path.
- Uses valid/ready handshakes on input and output, with a global stall.
- Carries a tag (destination register index) alongside the data so writeback can match results to instructions.

---
 rtl/shift_pkg.sv | 18 +
 rtl/left_shift_stage.sv | 43 ++++
 rtl/left_shift_pipe.sv | 62 ++++++
 tb/tb_left_shift_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths and per-stage record for left_shift_pipe (LSHIFT_ROTATE_EN adds rot)
package shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int TAG_W   = 5;

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        logic [TAG_W-1:0]   tag;
`ifdef LSHIFT_ROTATE_EN
        logic               rot;
`endif
    } shift_stage_t;

endpackage

// File: rtl/left_shift_stage.sv
// rtl/left_shift_stage.sv - one registered layer of the log shifter (shift by 2^STAGE_IDX; rotate under LSHIFT_ROTATE_EN)
module left_shift_stage
    import shift_pkg::*;
#(
    parameter int STAGE_IDX = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  shift_stage_t prev,
    output shift_stage_t cur
);

    localparam int SH = 1 << STAGE_IDX;

    logic [WIDTH-1:0] layer;
    shift_stage_t     nxt;

    always_comb begin
`ifdef LSHIFT_ROTATE_EN
        if (prev.rot) begin
            layer = {prev.data[WIDTH-SH-1:0], prev.data[WIDTH-1:WIDTH-SH]};
        end else begin
            layer = prev.data << SH;
        end
`else
        layer = prev.data << SH;
`endif
        nxt = prev;
        if (prev.shamt[STAGE_IDX]) begin
            nxt.data = layer;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= '0;
        end else if (enable) begin
            cur <= nxt;
        end
    end

endmodule

// File: rtl/left_shift_pipe.sv
// rtl/left_shift_pipe.sv - 5-stage pipelined logical left shifter with valid/ready and tag (optional LSHIFT_ROTATE_EN)
module left_shift_pipe
    import shift_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
`ifdef LSHIFT_ROTATE_EN
    input  logic               in_rot,
`endif
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    shift_stage_t link [0:SHAMT_W];
    logic         stall;
    logic         unused_tail;

    always_comb begin
        link[0]       = '0;
        link[0].valid = in_valid;
        link[0].data  = in_data;
        link[0].shamt = in_shamt;
        link[0].tag   = in_tag;
`ifdef LSHIFT_ROTATE_EN
        link[0].rot   = in_rot;
`endif
    end

    // A full output that is not being taken freezes the whole pipe.
    assign stall    = link[SHAMT_W].valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        left_shift_stage #(
            .STAGE_IDX(k)
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .enable(~stall),
            .prev  (link[k]),
            .cur   (link[k+1])
        );
    end

    assign out_valid = link[SHAMT_W].valid;
    assign out_data  = link[SHAMT_W].data;
    assign out_tag   = link[SHAMT_W].tag;

`ifdef LSHIFT_ROTATE_EN
    assign unused_tail = ^{link[SHAMT_W].shamt, link[SHAMT_W].rot};
`else
    assign unused_tail = ^link[SHAMT_W].shamt;
`endif

endmodule

// File: tb/tb_left_shift_pipe.sv
// tb/tb_left_shift_pipe.sv - directed self-checking bench for left_shift_pipe
module tb_left_shift_pipe;
    import shift_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
`ifdef LSHIFT_ROTATE_EN
    logic               in_rot;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    left_shift_pipe dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
`ifdef LSHIFT_ROTATE_EN
        .in_rot   (in_rot),
`endif
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic single(input string name, input logic [31:0] d, input logic [4:0] s,
                          input logic [4:0] t, input logic [31:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_tag   = t;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
            #1;
            chk({name, "_valid"}, 32'(out_valid), (i == 5) ? 32'd1 : 32'd0);
            if (i == 5) begin
                chk({name, "_data"}, out_data, e);
                chk({name, "_tag"}, 32'(out_tag), 32'(t));
            end
        end
    endtask

    logic [31:0] bp_exp  [6] = '{32'h3, 32'h6, 32'hC, 32'h18, 32'h30, 32'h60};
    logic [31:0] bub_exp [3] = '{32'h10, 32'h20, 32'h40};

    initial begin
        int sent;
        int got;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef LSHIFT_ROTATE_EN
        in_rot    = 1'b0;
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        single("msb", 32'h0000_0001, 5'd31, 5'd7, 32'h8000_0000);
        single("ones4", 32'hFFFF_FFFF, 5'd4, 5'd2, 32'hFFFF_FFF0);
        single("pass", 32'h1234_5678, 5'd0, 5'd9, 32'h1234_5678);

        // Backpressure: stall output for 3 cycles when the first result shows up.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 6);
            in_data   = 32'h3;
            in_shamt  = sent[4:0];
            in_tag    = sent[4:0];
            #1;
            if (cyc == 5) chk("bp_first_valid", 32'(out_valid), 32'd1);
            if (cyc >= 5 && cyc <= 7) begin
                chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
                chk("bp_hold_data", out_data, 32'h3);
                chk("bp_hold_tag", 32'(out_tag), 32'd0);
            end
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, bp_exp[got]);
                chk("bp_tag", 32'(out_tag), 32'(got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clock);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 32'(got), 32'd6);
        #1;
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Bubbles: ops on alternate cycles keep their spacing and tags.
        @(negedge clock);
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (cyc % 2 == 0) && (cyc < 6);
            in_data  = 32'h10;
            in_shamt = 5'(cyc / 2);
            in_tag   = 5'(cyc / 2 + 1);
            #1;
            chk("bub_valid", 32'(out_valid), (cyc == 5 || cyc == 7 || cyc == 9) ? 32'd1 : 32'd0);
            if (out_valid) begin
                chk("bub_tag", 32'(out_tag), 32'((cyc - 5) / 2 + 1));
                chk("bub_data", out_data, bub_exp[(cyc - 5) / 2]);
            end
            @(negedge clock);
        end

        // Reset mid-flight with a stalled result at the output.
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = (cyc < 3);
            in_data  = 32'(cyc + 1);
            in_shamt = 5'd1;
            in_tag   = 5'(cyc + 4);
            #1;
            if (cyc == 5) chk("rmf_pre_valid", 32'(out_valid), 32'd1);
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rmf_valid", 32'(out_valid), 32'd0);
        chk("rmf_data", out_data, 32'd0);
        chk("rmf_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clock);
            #1;
            chk("rmf_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef LSHIFT_ROTATE_EN
        @(negedge clock);
        in_rot = 1'b1;
        single("rot1", 32'h8000_0001, 5'd1, 5'd3, 32'h0000_0003);
        in_rot = 1'b0;
        single("shl1", 32'h8000_0001, 5'd1, 5'd4, 32'h0000_0002);
        in_rot = 1'b1;
        single("rot4", 32'hF000_0000, 5'd4, 5'd5, 32'h0000_000F);
        in_rot = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
